spi_master_arb: RTL and testbench
=================================

// Module: spi_master_arb
// PURPOSE
//  Shares one SPI master (sclk/mosi/cs) between NREQ on-chip requesters, each sending 8-bit frames.
//  Drives mode-0 SPI: peripherals sample mosi on rising sclk, MSB first, cs active low.
//  Sits between requester blocks and the SPI byte-receiving peripherals.
//  Contains the round-robin arbiter, sclk divider and frame sequencer.
// PARAMETERS
//  NREQ     2  number of requesters, 1..8
//  CLK_DIV  4  clk cycles per sclk half-period, >=1
//  CS_GAP   2  minimum cs-high time between frames, in sclk half-periods, >=1
// PORTS
//  clk       in   1         system clock, all logic on posedge
//  rst_n     in   1         asynchronous, active-low reset
//  req       in   NREQ      level request per requester
//  req_data  in   8*NREQ    frame byte per requester; requester i uses [8i+7:8i]
//  gnt       out  NREQ      one-cycle pulse: requester's byte captured
//  done      out  NREQ      one-cycle pulse: requester's frame finished (cs rising)
//  busy      out  1         high from grant cycle through end of GAP
//  sclk      out  1         SPI clock, idle low
//  mosi      out  1         SPI data, MSB first
//  cs        out  1         SPI chip select, active low
// BEHAVIOUR
//  - Reset (async, immediate): cs=1, sclk=0, mosi=0, gnt=0, done=0, busy=0; FSM=IDLE; rr pointer=0.
//  - FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. All outputs are registered.
//  - IDLE: if |req, winner = first set req at or after pointer (cyclic).
//    Next edge: gnt[winner]=1 for one cycle; shreg<=req_data[winner]; owner<=winner;
//    pointer<=winner+1 (mod NREQ); cs<=0; mosi<=bit7; busy<=1; goto SETUP.
//  - SETUP: CLK_DIV cycles with cs low, sclk low; goto SHIFT.
//  - SHIFT: sclk toggles every CLK_DIV cycles, 16 half-periods, starting with a rise.
//    On each fall except the 8th, shift shreg left and put the new bit7 on mosi.
//    mosi is therefore stable for a full half-period around each rise.
//    Exactly 8 rises per frame; bit counter is 3 bits plus an edge phase.
//    After the 8th fall: sclk low; goto HOLD.
//  - HOLD: CLK_DIV cycles; then cs<=1, mosi<=0, done[owner]=1 for one cycle; goto GAP.
//  - GAP: CS_GAP*CLK_DIV cycles cs high; then busy<=0; goto IDLE.
//  - Timing: cs low for CLK_DIV*18 clks (72 at defaults); next frame's gnt comes no earlier
//    than 1 cycle after GAP ends.
//  - Handshake: req_data must be stable while req is high and gnt has not pulsed.
//    req is sampled only in IDLE. A req still high after gnt is a new request: a continuous
//    req yields back-to-back frames, rotated against other requesters.
//  - Simultaneous requests: resolved by pointer. No requester is starved; worst-case wait is
//    NREQ-1 frames. gnt and done are never active for two requesters at once.
//  - req deasserted during a frame: no effect; the frame completes.
//  - Reset mid-frame: the frame is truncated with cs high immediately and no done pulse.
//    The receiver sees a short frame; no recovery sequence is issued.
//  - Owner index width: $clog2(NREQ), minimum 1. Divider counter width: $clog2(CLK_DIV*CS_GAP+1).
// STRUCTURE
//  - Package spi_ctrl_pkg: FSM state typedef, FRAME_BITS=8, localparam helpers for counter widths.
//  - Sub-module spi_rr_arbiter (req, pointer -> one-hot winner + index), purely combinational;
//    pointer register lives in the parent.
//  - Divider counter, bit counter and shift register in the parent.
// TESTING (NREQ=2, CLK_DIV=4, CS_GAP=2 unless stated; a bench receiver samples mosi on sclk rise)
//  1. req[0]=1, data 0xA5 -> gnt[0] next edge; cs low 72 clks; 8 rises; mosi 1,0,1,0,0,1,0,1;
//     done[0] with cs rise; receiver byte 0xA5.
//  2. req=2'b11 after reset, data0=0x3C, data1=0xC3 -> frame 0x3C (gnt[0]), then 0xC3 (gnt[1]);
//     cs high >=8 clks between frames.
//  3. req held 2'b11 for 4 frames -> gnt order 0,1,0,1; busy stays low 1 cycle max between frames.
//  4. rst_n low after 4th rise of a frame -> cs=1, sclk=0, busy=0 same clk (async); no done;
//     next req gives full correct frame.
//  5. CLK_DIV=1, data 0xFF then 0x00 -> sclk period 2 clks; cs low 18 clks; bytes received intact.
//  6. NREQ=3, req=3'b101 with pointer=1 -> gnt[2] first, then gnt[0].

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and width helpers for the arbitrated SPI master.
package spi_ctrl_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int div_width(input int clk_div, input int cs_gap);
    int w;
    w = $clog2(clk_div * cs_gap + 1);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after pointer, wrapping.
module spi_rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx,
  output logic            valid
);

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    // upper pass covers pointer..NREQ-1, lower pass wraps to 0..pointer-1
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (IW'(i) >= pointer)) begin
        valid      = 1'b1;
        winner_idx = IW'(i);
        winner[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i]) begin
        valid      = 1'b1;
        winner_idx = IW'(i);
        winner[i]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin shared mode-0 SPI master; req is a level request sampled only in IDLE,
// req_data must hold while req is high until gnt pulses, gnt marks the byte as captured.
module spi_master_arb
  import spi_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs
);

  localparam int IW = idx_width(NREQ);
  localparam int DW = div_width(CLK_DIV, CS_GAP);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(CLK_DIV * CS_GAP - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NREQ - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    phase_q, phase_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]         gnt_d, done_d;
  logic                    busy_d, sclk_d, mosi_d, cs_d;

  logic [NREQ-1:0]         arb_winner;
  logic [IW-1:0]           arb_idx;
  logic                    arb_valid;
  logic [FRAME_BITS-1:0]   sel_byte;
  logic                    half_end;

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req        (req),
    .pointer    (ptr_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  assign sel_byte = req_data[{arb_idx, 3'b000} +: FRAME_BITS];
  assign half_end = (div_q == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shreg_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      cs      <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = busy;
    sclk_d  = sclk;
    mosi_d  = mosi;
    cs_d    = cs;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_winner;
          shreg_d = sel_byte;
          owner_d = arb_idx;
          ptr_d   = (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
          cs_d    = 1'b0;
          mosi_d  = sel_byte[FRAME_BITS-1];
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (half_end) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (half_end) begin
          div_d = '0;
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            // the last fall leaves mosi on bit 0 until HOLD clears it
            if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
              mosi_d  = shreg_q[FRAME_BITS-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          div_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = NREQ'(1) << owner_q;
          state_d = ST_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench: three instances (defaults, CLK_DIV=1, NREQ=3) with per-instance SPI receivers.
module tb_spi_master_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_a = '0, gnt_a, done_a;
  logic [15:0] data_a = '0;
  logic        busy_a, sclk_a, mosi_a, cs_a;

  logic [1:0]  req_b = '0, gnt_b, done_b;
  logic [15:0] data_b = '0;
  logic        busy_b, sclk_b, mosi_b, cs_b;

  logic [2:0]  req_c = '0, gnt_c, done_c;
  logic [23:0] data_c = '0;
  logic        busy_c, sclk_c, mosi_c, cs_c;

  spi_master_arb #(.NREQ(2), .CLK_DIV(4), .CS_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(data_a), .gnt(gnt_a), .done(done_a),
    .busy(busy_a), .sclk(sclk_a), .mosi(mosi_a), .cs(cs_a)
  );

  spi_master_arb #(.NREQ(2), .CLK_DIV(1), .CS_GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(data_b), .gnt(gnt_b), .done(done_b),
    .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b)
  );

  spi_master_arb #(.NREQ(3), .CLK_DIV(4), .CS_GAP(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .req_data(data_c), .gnt(gnt_c), .done(done_c),
    .busy(busy_c), .sclk(sclk_c), .mosi(mosi_c), .cs(cs_c)
  );

  // receivers: mode 0, sample mosi on sclk rise while cs is low
  logic [7:0] rx_a = '0, rx_b = '0, rx_c = '0;
  int rises_a = 0, rises_b = 0;
  always @(posedge sclk_a) if (!cs_a) begin rx_a <= {rx_a[6:0], mosi_a}; rises_a <= rises_a + 1; end
  always @(posedge sclk_b) if (!cs_b) begin rx_b <= {rx_b[6:0], mosi_b}; rises_b <= rises_b + 1; end
  always @(posedge sclk_c) if (!cs_c) rx_c <= {rx_c[6:0], mosi_c};

  int low_run_a = 0, last_low_a = 0, done_cnt_a = 0;
  always @(posedge clk) begin
    if (!cs_a) low_run_a <= low_run_a + 1;
    else begin
      if (low_run_a != 0) last_low_a <= low_run_a;
      low_run_a <= 0;
    end
    if (|done_a) done_cnt_a <= done_cnt_a + 1;
  end

  longint last_rise_b = 0, period_b = 0;
  always @(posedge sclk_b) begin
    period_b    <= longint'($time) - last_rise_b;
    last_rise_b <= longint'($time);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] gnt_of(input int d);
    case (d)
      0:       return {1'b0, gnt_a};
      1:       return {1'b0, gnt_b};
      default: return gnt_c;
    endcase
  endfunction

  function automatic logic [2:0] done_of(input int d);
    case (d)
      0:       return {1'b0, done_a};
      1:       return {1'b0, done_b};
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wait_gnt(input int d, output logic [2:0] g, output int cyc);
    g = '0;
    cyc = 0;
    while (g == 3'b000 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      g = gnt_of(d);
    end
  endtask

  task automatic wait_done(input int d, output logic [2:0] g, output int cyc);
    g = '0;
    cyc = 0;
    while (g == 3'b000 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      g = done_of(d);
    end
  endtask

  task automatic wait_idle(input int d, output int cyc);
    cyc = 0;
    while (busy_of(d) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_reached", {31'd0, busy_of(d)}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    int cyc, r0, bl, dc0;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs_a", {24'd0, cs_a, sclk_a, mosi_a, busy_a, gnt_a, done_a}, 32'h80);
    check("rst_cs_bc", {30'd0, cs_b, cs_c}, 32'd3);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single frame 0xA5 from requester 0
    data_a = 16'h00A5;
    req_a  = 2'b01;
    r0 = rises_a;
    wait_gnt(0, g, cyc);
    check("t1_gnt", g, 3'b001);
    check("t1_gnt_latency", cyc, 1);
    check("t1_start_cs_busy_mosi", {29'd0, cs_a, busy_a, mosi_a}, 32'b011);
    req_a = 2'b00;
    wait_done(0, g, cyc);
    check("t1_done", g, 3'b001);
    check("t1_done_cycles", cyc, 72);
    check("t1_cs_high_at_done", {31'd0, cs_a}, 1);
    check("t1_busy_at_done", {31'd0, busy_a}, 1);
    check("t1_rises", rises_a - r0, 8);
    check("t1_rx", rx_a, 8'hA5);
    wait_idle(0, cyc);
    check("t1_gap_cycles", cyc, 8);
    check("t1_cs_low_len", last_low_a, 72);
    @(negedge clk);
    check("t1_no_regrant", gnt_a, 2'b00);

    // 2: simultaneous requests after reset
    do_reset();
    data_a = 16'hC33C;
    req_a  = 2'b11;
    wait_gnt(0, g, cyc);
    check("t2_gnt0", g, 3'b001);
    wait_done(0, g, cyc);
    check("t2_rx0", rx_a, 8'h3C);
    wait_gnt(0, g, cyc);
    check("t2_gnt1", g, 3'b010);
    check("t2_cs_gap_ge8", {31'd0, cyc >= 8}, 1);
    req_a = 2'b00;
    wait_done(0, g, cyc);
    check("t2_done1", g, 3'b010);
    check("t2_rx1", rx_a, 8'hC3);

    // 3: continuous requests rotate 0,1,0,1
    do_reset();
    data_a = 16'h9669;
    req_a  = 2'b11;
    for (int f = 0; f < 4; f++) begin
      if (f == 0) begin
        wait_gnt(0, g, cyc);
      end else begin
        bl = 0;
        g = '0;
        cyc = 0;
        while (g == 3'b000 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (!busy_a) bl++;
          g = {1'b0, gnt_a};
        end
        check("t3_busy_low_cycles", bl, 1);
      end
      check("t3_gnt_order", g, (f % 2 == 0) ? 3'b001 : 3'b010);
      if (f == 3) req_a = 2'b00;
      wait_done(0, g, cyc);
      check("t3_rx", rx_a, (f % 2 == 0) ? 8'h69 : 8'h96);
    end
    wait_idle(0, cyc);

    // 4: reset after the 4th rise truncates the frame
    data_a = 16'h005A;
    req_a  = 2'b01;
    wait_gnt(0, g, cyc);
    req_a = 2'b00;
    r0 = rises_a;
    dc0 = done_cnt_a;
    cyc = 0;
    while ((rises_a - r0) < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_four_rises", rises_a - r0, 4);
    #2 rst_n = 1'b0;
    #1 check("t4_async_reset", {29'd0, cs_a, sclk_a, busy_a}, 32'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("t4_no_done", done_cnt_a - dc0, 0);
    check("t4_cs_idle", {31'd0, cs_a}, 1);
    data_a = 16'h0096;
    req_a  = 2'b01;
    wait_gnt(0, g, cyc);
    check("t4_regrant", g, 3'b001);
    req_a = 2'b00;
    r0 = rises_a;
    wait_done(0, g, cyc);
    check("t4_done_cycles", cyc, 72);
    check("t4_rises", rises_a - r0, 8);
    check("t4_rx", rx_a, 8'h96);

    // 5: CLK_DIV=1 instance, bytes 0xFF then 0x00
    data_b = 16'h00FF;
    req_b  = 2'b01;
    wait_gnt(1, g, cyc);
    check("t5_gnt0", g, 3'b001);
    req_b = 2'b00;
    r0 = rises_b;
    wait_done(1, g, cyc);
    check("t5_cs_low_0", cyc, 18);
    check("t5_rises", rises_b - r0, 8);
    check("t5_rx_ff", rx_b, 8'hFF);
    check("t5_sclk_period", period_b[31:0], 20);
    wait_idle(1, cyc);
    req_b = 2'b10;
    wait_gnt(1, g, cyc);
    check("t5_gnt1", g, 3'b010);
    req_b = 2'b00;
    wait_done(1, g, cyc);
    check("t5_cs_low_1", cyc, 18);
    check("t5_rx_00", rx_b, 8'h00);

    // 6: NREQ=3, move pointer to 1 then request 3'b101
    data_c = 24'h332211;
    req_c  = 3'b001;
    wait_gnt(2, g, cyc);
    check("t6_prime_gnt", g, 3'b001);
    req_c = 3'b000;
    wait_done(2, g, cyc);
    wait_idle(2, cyc);
    req_c = 3'b101;
    wait_gnt(2, g, cyc);
    check("t6_first_gnt", g, 3'b100);
    wait_done(2, g, cyc);
    check("t6_first_done", g, 3'b100);
    check("t6_rx2", rx_c, 8'h33);
    wait_gnt(2, g, cyc);
    check("t6_second_gnt", g, 3'b001);
    req_c = 3'b000;
    wait_done(2, g, cyc);
    check("t6_second_done", g, 3'b001);
    check("t6_rx0", rx_c, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
